// File: rtl/garage_door_position_sensor.sv
// -----------------------------------------------------------------------------
// garage_door_position_sensor
//
// Plant model of a garage door. It consumes the controller's motor commands
// and produces the limit-switch signals the controller expects. Door position
// is tracked as a step count advanced by a prescaler while the motor runs.
// Illegal motor commands (both directions at once) latch a fault.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous, active-high reset
//   UP_M       in   open-motor command
//   DN_M       in   close-motor command
//   UP_Max     out  door fully open (Position == TRAVEL_STEPS)
//   DN_Max     out  door fully closed (Position == 0)
//   Position   out  current door position, 0 = closed
//   Moving     out  door is opening or closing
//   Fault      out  illegal command seen; held until RST
//   state_dbg  out  raw FSM state (0 IDLE, 1 OPENING, 2 CLOSING, 3 FAULT)
//
// Handshake: none. UP_M/DN_M are level commands sampled every rising edge;
// outputs are levels valid after the edge that updates them.
// -----------------------------------------------------------------------------
module garage_door_position_sensor #(
  parameter int TRAVEL_STEPS = 100,
  parameter int STEP_DIV     = 4,
  parameter int POS_W        = 8,
  parameter bit INIT_CLOSED  = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UP_M,
  input  logic             DN_M,
  output logic             UP_Max,
  output logic             DN_Max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault,
  output logic [1:0]       state_dbg
);

  // Prescaler needs at least one bit even when STEP_DIV == 1.
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [POS_W-1:0] POS_TOP   = POS_W'(TRAVEL_STEPS);
  localparam logic [POS_W-1:0] POS_RESET = INIT_CLOSED ? '0 : POS_TOP;
  localparam logic [PW-1:0]    PRE_LAST  = PW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [POS_W-1:0] pos;

  // Limit switches decode the position register only.
  assign UP_Max    = (pos == POS_TOP);
  assign DN_Max    = (pos == '0);
  assign Position  = pos;
  assign Moving    = (state == OPENING) || (state == CLOSING);
  assign Fault     = (state == FAULT);
  assign state_dbg = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      presc <= '0;
      pos   <= POS_RESET;
    end else begin
      case (state)
        IDLE: begin
          presc <= '0;
          if (UP_M && DN_M) begin
            state <= FAULT;
          end else if (UP_M && !UP_Max) begin
            state <= OPENING;
          end else if (DN_M && !DN_Max) begin
            state <= CLOSING;
          end
        end

        OPENING: begin
          // Fault check wins over a step due on this same edge.
          if (UP_M && DN_M) begin
            state <= FAULT;
          end else if (!UP_M) begin
            // Stop or reversal: position holds, partial progress dropped.
            state <= IDLE;
            presc <= '0;
          end else if (presc == PRE_LAST) begin
            pos   <= pos + 1'b1;
            presc <= '0;
            if (pos + 1'b1 == POS_TOP) state <= IDLE;
          end else begin
            presc <= presc + 1'b1;
          end
        end

        CLOSING: begin
          if (UP_M && DN_M) begin
            state <= FAULT;
          end else if (!DN_M) begin
            state <= IDLE;
            presc <= '0;
          end else if (presc == PRE_LAST) begin
            pos   <= pos - 1'b1;
            presc <= '0;
            if (pos == POS_W'(1)) state <= IDLE;
          end else begin
            presc <= presc + 1'b1;
          end
        end

        // Latched until reset; position frozen, inputs ignored.
        FAULT: state <= FAULT;

        default: state <= FAULT;
      endcase
    end
  end

endmodule
